// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 frame receiver and related PS/2 blocks.
package ps2_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } ps2_state_t;

    // Start + data + parity + stop.
    function automatic int frame_bits(input int data_bits);
        return data_bits + 3;
    endfunction

    // Odd parity: data ones plus parity bit must be odd, otherwise flag an error.
    function automatic logic odd_parity_fail(input logic data_xor, input logic parity_bit);
        return ~(data_xor ^ parity_bit);
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the PS/2 clock and data lines and flags one-cycle falling edges of
// the synced clock. Flops reset to 1 (idle level) so reset never fakes an edge.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic data_sync,
    output logic fe
);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign fe        = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign data_sync = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver with start qualification, odd-parity and stop checks.
// Optional inactivity timeout enabled by defining PS2_FRAME_TIMEOUT_EN.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter  int DATA_BITS      = 8,
    parameter  int SYNC_STAGES    = 2,
    parameter  int TIMEOUT_CYCLES = 12500,
    localparam int FRAME_BITS     = frame_bits(DATA_BITS),
    localparam int BCW            = $clog2(FRAME_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk_in,
    input  logic                 ps2_data_in,
    output logic [DATA_BITS-1:0] frame_data,
    output logic                 frame_valid,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 timeout,
    output logic [BCW-1:0]       bit_count,
    output logic                 busy
);

    localparam logic [BCW-1:0] LAST_DATA_IDX = BCW'(DATA_BITS);
    localparam logic [BCW-1:0] PARITY_IDX    = BCW'(DATA_BITS + 1);

    ps2_state_t           state_q, state_d;
    logic [BCW-1:0]       bit_count_q, bit_count_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [DATA_BITS-1:0] frame_data_q, frame_data_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 framing_err_q, framing_err_d;
    logic                 timeout_q, timeout_d;
    logic                 data_s, fe, tmo_hit;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .data_sync  (data_s),
        .fe         (fe)
    );

`ifdef PS2_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    // Counts RECV cycles without an edge; an edge always wins over the abort.
    always_comb begin
        idle_cnt_d = '0;
        tmo_hit    = 1'b0;
        if (state_q == RECV && !fe) begin
            if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) tmo_hit = 1'b1;
            else                                       idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idle_cnt_q <= '0;
        else     idle_cnt_q <= idle_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign tmo_hit            = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        bit_count_d   = bit_count_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        frame_data_d  = frame_data_q;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        frame_valid_d = 1'b0;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fe && !data_s) begin
                    state_d     = RECV;
                    bit_count_d = BCW'(1);
                end
            end
            RECV: begin
                if (fe) begin
                    if (bit_count_q <= LAST_DATA_IDX) begin
                        shift_d     = {data_s, shift_q[DATA_BITS-1:1]};
                        bit_count_d = bit_count_q + 1'b1;
                    end else if (bit_count_q == PARITY_IDX) begin
                        parity_d    = data_s;
                        bit_count_d = bit_count_q + 1'b1;
                    end else begin
                        frame_data_d  = shift_q;
                        parity_err_d  = odd_parity_fail(^shift_q, parity_q);
                        framing_err_d = ~data_s;
                        frame_valid_d = 1'b1;
                        bit_count_d   = '0;
                        state_d       = IDLE;
                    end
                end else if (tmo_hit) begin
                    timeout_d   = 1'b1;
                    bit_count_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_count_q   <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_count_q   <= bit_count_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            timeout_q     <= timeout_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign timeout     = timeout_q;
    assign bit_count   = bit_count_q;
    assign busy        = (state_q == RECV);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed and randomized bench for ps2_frame_receiver against a frame-level reference model.
module tb_ps2_frame_receiver;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TMO         = 100;
    localparam int HALF        = 20;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 ps2_clk_in = 1'b1;
    logic                 ps2_data_in = 1'b1;
    logic [DATA_BITS-1:0] frame_data;
    logic                 frame_valid, parity_err, framing_err, timeout, busy;
    logic [3:0]           bit_count;

    int tests = 0;
    int fails = 0;

    int                   valid_cnt = 0;
    int                   tmo_cnt = 0;
    int                   long_pulse = 0;
    logic                 prev_valid = 1'b0;
    logic [DATA_BITS-1:0] cap_data = '0;
    logic                 cap_perr = 1'b0;
    logic                 cap_ferr = 1'b0;

    ps2_frame_receiver #(
        .DATA_BITS(DATA_BITS), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .frame_data(frame_data), .frame_valid(frame_valid), .parity_err(parity_err),
        .framing_err(framing_err), .timeout(timeout), .bit_count(bit_count), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) begin
            valid_cnt++;
            cap_data = frame_data;
            cap_perr = parity_err;
            cap_ferr = framing_err;
            if (prev_valid) long_pulse++;
        end
        if (timeout) tmo_cnt++;
        prev_valid = frame_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_edge(input logic d);
        ps2_data_in = d;
        wait_cycles(HALF);
        ps2_clk_in = 1'b0;
        wait_cycles(HALF);
        ps2_clk_in = 1'b1;
    endtask

    // Full frame; returns clk cycles from the stop-bit pin edge to frame_valid (0 if never seen).
    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic par,
                              input logic stop, output int lat);
        lat = 0;
        ps2_edge(1'b0);
        for (int i = 0; i < DATA_BITS; i++) ps2_edge(d[i]);
        ps2_edge(par);
        ps2_data_in = stop;
        wait_cycles(HALF);
        ps2_clk_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && frame_valid) lat = i;
        end
        wait_cycles(HALF - 10);
        ps2_clk_in = 1'b1;
        ps2_data_in = 1'b1;
        wait_cycles(HALF);
    endtask

    function automatic logic good_parity(input logic [DATA_BITS-1:0] d);
        return ($countones(d) % 2 == 0);
    endfunction

    task automatic frame_case(input string tag, input logic [DATA_BITS-1:0] d,
                              input logic par, input logic stop);
        int v0, lat;
        logic exp_perr;
        v0 = valid_cnt;
        exp_perr = (($countones(d) + int'(par)) % 2 == 0);
        send_frame(d, par, stop, lat);
        check({tag, " valid count"}, valid_cnt, v0 + 1);
        check({tag, " data"}, cap_data, d);
        check({tag, " parity_err"}, cap_perr, exp_perr);
        check({tag, " framing_err"}, cap_ferr, !stop);
        check({tag, " latency"}, lat, SYNC_STAGES + 1);
        check({tag, " held data"}, frame_data, d);
        check({tag, " bit_count idle"}, bit_count, 0);
        check({tag, " busy idle"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " frame_data"}, frame_data, 0);
        check({tag, " frame_valid"}, frame_valid, 0);
        check({tag, " parity_err"}, parity_err, 0);
        check({tag, " framing_err"}, framing_err, 0);
        check({tag, " timeout"}, timeout, 0);
        check({tag, " bit_count"}, bit_count, 0);
        check({tag, " busy"}, busy, 0);
    endtask

    initial begin
        int v0, t0;
        logic [DATA_BITS-1:0] rd;
        logic rpar, rstop;

        rst = 1'b1;
        wait_cycles(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_cycles(5);

        frame_case("good 1C", 8'h1C, 1'b0, 1'b1);
        frame_case("parity 1C", 8'h1C, 1'b1, 1'b1);
        frame_case("framing F0", 8'hF0, 1'b1, 1'b0);

        v0 = valid_cnt;
        repeat (3) ps2_edge(1'b1);
        wait_cycles(HALF);
        check("no start bit_count", bit_count, 0);
        check("no start busy", busy, 0);
        check("no start valid", valid_cnt, v0);

        ps2_edge(1'b0);
        wait_cycles(5);
        check("start bit_count", bit_count, 1);
        check("start busy", busy, 1);
        repeat (3) ps2_edge(1'b1);
        wait_cycles(5);
        check("mid frame bit_count", bit_count, 4);
        rst = 1'b1;
        wait_cycles(2);
        check_reset_outputs("mid reset");
        rst = 1'b0;
        wait_cycles(5);
        frame_case("after reset 1C", 8'h1C, 1'b0, 1'b1);

        for (int n = 0; n < 20; n++) begin
            rd    = DATA_BITS'($urandom);
            rpar  = ($urandom_range(0, 3) == 0) ? ~good_parity(rd) : good_parity(rd);
            rstop = ($urandom_range(0, 3) != 0);
            frame_case("random", rd, rpar, rstop);
        end

        t0 = tmo_cnt;
        ps2_edge(1'b0);
        repeat (4) ps2_edge(1'b1);
        wait_cycles(2);
        check("partial bit_count", bit_count, 5);
        check("no early timeout", tmo_cnt, t0);
        wait_cycles(2 * TMO);
`ifdef PS2_FRAME_TIMEOUT_EN
        check("timeout pulses", tmo_cnt, t0 + 1);
        check("timeout bit_count", bit_count, 0);
        check("timeout busy", busy, 0);
        check("timeout keeps data", frame_data, cap_data);
        frame_case("post timeout F0", 8'hF0, 1'b1, 1'b1);
`else
        check("timeout tied low", tmo_cnt, t0);
        check("partial persists", bit_count, 5);
        check("partial busy", busy, 1);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(5);
        frame_case("post flush F0", 8'hF0, 1'b1, 1'b1);
`endif

        check("valid pulse width", long_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_frame_receiver.md
# ps2_frame_receiver

Parametrised PS/2 device-to-host frame receiver: counts falling edges of the PS/2 clock line, deserialises start, data, parity and stop bits, and presents a checked data word with a one-cycle valid strobe. Successor to the fixed 11-edge frame counter. Adds a generic data width, start-bit qualification, odd-parity and stop-bit checking, and an optional inactivity timeout that resynchronises the frame counter. Sits between the PS/2 pin synchronisers and the scan-code decoder in the keyboard interface.

## Interface
- DATA_BITS, 8, data bits per frame. Frame length FRAME_BITS = DATA_BITS+3 is derived, not a parameter.
- SYNC_STAGES, 2, synchroniser flops on ps2_clk_in and ps2_data_in (≥2).
- TIMEOUT_CYCLES, 12500, clk cycles with no PS/2 edge that abort a partial frame (250 µs at 50 MHz). Used only with the timeout macro.
- clk  in  1  system clock; one clock domain for the whole block.
- rst  in  1  reset, synchronous, active-high.
- ps2_clk_in  in  1  raw PS/2 clock line, asynchronous, idles high.
- ps2_data_in  in  1  raw PS/2 data line, asynchronous, idles high.
- frame_data  out  DATA_BITS  last received data word, LSB first on the wire. Holds until the next frame completes.
- frame_valid  out  1  one-cycle pulse when a frame completes.
- parity_err  out  1  odd-parity failure of the last frame. Valid with frame_valid and held with frame_data.
- framing_err  out  1  stop bit was 0 in the last frame. Valid with frame_valid and held.
- timeout  out  1  one-cycle pulse when a partial frame is aborted.
- bit_count  out  $clog2(FRAME_BITS+1)  edges accepted in the current frame, 0..FRAME_BITS-1.
- busy  out  1  high while a frame is in progress (state RECV).

## Operation
- Both lines pass through SYNC_STAGES flops. A falling edge `fe` is flagged when the previous synced clock sample is 1 and the current sample is 0. Data is sampled from the synced data line in the same cycle as `fe`.
- State machine: IDLE and RECV.
  - IDLE, `fe` with data=0 (start bit): go to RECV and set bit_count=1.
  - IDLE, `fe` with data=1: ignore the edge; bit_count stays 0.
  - RECV, `fe` with bit_count 1..DATA_BITS: shift data into the MSB of a shift register (LSB-first reception) and increment bit_count.
  - RECV, `fe` with bit_count=DATA_BITS+1: store the parity bit and increment bit_count.
  - RECV, `fe` with bit_count=DATA_BITS+2 (stop bit): load frame_data from the shift register.
    - parity_err = ~(^{data, parity}).
    - framing_err = ~stop.
    - frame_valid=1 for one cycle.
    - bit_count=0 and return to IDLE.
- frame_valid, parity_err and framing_err update together. No back-pressure: the consumer must take frame_data before the next frame completes, which is at least 11 PS/2 clock periods later.
- rst mid-frame discards the partial frame. Already-held frame_data is cleared.
- Reset values:
  - state IDLE.
  - bit_count, frame_data, frame_valid, parity_err, framing_err, timeout and busy all 0.
  - Synchroniser and previous-sample flops reset to 1, so no spurious edge occurs after reset.

## Timing
- Latency: frame_valid rises SYNC_STAGES+1 clk cycles (+1 for asynchronous sampling) after the stop-bit falling edge at the pin, and is high for exactly 1 cycle.
- bit_count and busy are registered and change on the clk edge that processes `fe`.
- One PS/2 edge produces exactly one `fe`. The PS/2 clock (10–16.7 kHz) is always far slower than clk.
- rst takes priority over every edge and timeout event in the same cycle.

## Configuration
- PS2_FRAME_TIMEOUT_EN defined:
  - An idle counter of $clog2(TIMEOUT_CYCLES+1) bits clears on every `fe` and counts while in RECV.
  - At TIMEOUT_CYCLES the block pulses timeout for 1 cycle, sets bit_count=0 and returns to IDLE. frame_data and the error flags are unchanged.
  - If `fe` occurs in the same cycle as the timeout, `fe` wins and the counter clears.
- PS2_FRAME_TIMEOUT_EN undefined:
  - No idle counter is built and timeout is tied to 0.
  - A partial frame persists until further edges arrive or rst is asserted.

## Structure
- Package ps2_pkg: the state enum (IDLE, RECV), the FRAME_BITS derivation, and an odd-parity check function.
- Sub-module ps2_sync_edge: synchronises both lines and outputs the synced data plus a one-cycle `fe`. Instantiated once here and reusable by a future host-to-device transmitter.

## Test plan
- Reset: pulse rst high for 2 cycles, including once mid-frame after 4 edges → all outputs 0. A subsequent clean frame of 0x1C is received correctly.
- Good frame: start 0, data 0x1C LSB first, parity 0, stop 1 → exactly one frame_valid pulse; frame_data=0x1C, parity_err=0, framing_err=0, bit_count back to 0.
- Parity error: 0x1C with parity bit 1 → frame_valid pulses, frame_data=0x1C, parity_err=1, framing_err=0.
- Framing error: 0xF0 with correct parity 1 and stop bit 0 → frame_valid pulses, frame_data=0xF0, framing_err=1, parity_err=0.
- No start bit: 3 edges with data=1 while in IDLE → bit_count stays 0, busy 0, no frame_valid.
- Timeout (PS2_FRAME_TIMEOUT_EN defined, TIMEOUT_CYCLES=100): 5 edges, then 100 idle cycles → timeout pulses once and bit_count=0. The next full frame 0xF0 gives frame_valid with frame_data=0xF0 and no errors.
